// File: rtl/icache_responder_if.sv
// ---------------------------------------------------------------------------
// icache_responder_if
//   Bundles the instruction-fetch port (datapath side), the memory-controller
//   read port and the statistics outputs of icache_responder.
//
//   Datapath side : imemREN, imemaddr, iflush  -> cache
//                   ihit, imemload             <- cache
//   Memory side   : iREN, iaddr                <- cache
//                   iload, iwait               -> cache
//   Statistics    : hit_count, miss_count      <- cache (zero unless enabled)
//
//   Modports: slave  = the cache itself
//             master = whatever drives the cache (datapath + memory model)
// ---------------------------------------------------------------------------
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iflush, iload, iwait,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, iflush, iload, iwait,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
//   Direct-mapped, one-word-per-line instruction cache between the fetch
//   stage and the memory controller. Hits answer in the same cycle; a miss
//   latches the word address, requests it from memory (iREN/iaddr) until
//   iwait drops, fills the line and lets the request hit the cycle after.
//
//   Ports:
//     CLK  - clock, rising edge
//     RST  - asynchronous active-high reset
//     bus  - icache_responder_if.slave (fetch port, memory port, counters)
//
//   Parameters:
//     NUM_SETS - number of lines (power of two, >= 2)
//
//   Optional feature (macro ICACHE_STATS_EN):
//     defined   -> saturating hit_count / miss_count counters
//     undefined -> no counter flops, both outputs tied to zero
// ---------------------------------------------------------------------------
module icache_responder #(
  parameter  int NUM_SETS = 16,
  localparam int IDX_W    = $clog2(NUM_SETS)
) (
  input logic           CLK,
  input logic           RST,
  icache_responder_if.slave bus
);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t              state_q;
  logic                iren_q;
  logic [31:0]         miss_addr_q;   // word-aligned; also drives iaddr
  logic [NUM_SETS-1:0] valid_vec;

  // Tag and data use combinational read so a hit is answered the same cycle.
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [31:0]         data_mem [NUM_SETS];

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                hit;
  logic [31:0]         load_data;
  logic                miss_start;
  logic                fill;
  logic                unused_ok;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[31:IDX_W+2];
  assign unused_ok = &{1'b0, bus.imemaddr[1:0]};

  always_comb begin
    hit        = 1'b0;
    load_data  = 32'h0;
    // A flush in the same cycle suppresses the hit; the request then counts
    // as a miss and is refetched.
    if (state_q == IDLE && bus.imemREN && !bus.iflush &&
        valid_vec[req_idx] && tag_mem[req_idx] == req_tag) begin
      hit       = 1'b1;
      load_data = data_mem[req_idx];
    end
    miss_start = (state_q == IDLE) && bus.imemREN && !hit;
    fill       = (state_q == MISS) && !bus.iwait;
  end

  // Control FSM with registered memory-side outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      iren_q      <= 1'b0;
      miss_addr_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            miss_addr_q <= {bus.imemaddr[31:2], 2'b00};
            iren_q      <= 1'b1;
            state_q     <= MISS;
          end
        end
        MISS: begin
          // Address/request changes are ignored here; the latched fill
          // always completes and the new request is judged back in IDLE.
          if (!bus.iwait) begin
            iren_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-line valid bits: the fill of a line beats a coincident flush.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_valid
      logic v_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                   v_q <= 1'b0;
        else if (fill && fill_idx == IDX_W'(gi))   v_q <= 1'b1;
        else if (bus.iflush)                       v_q <= 1'b0;
      end
      assign valid_vec[gi] = v_q;
    end
  endgenerate

  // Line storage needs no reset: valid_vec gates every read.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.iload;
    end
  end

  assign bus.ihit     = hit;
  assign bus.imemload = load_data;
  assign bus.iREN     = iren_q;
  assign bus.iaddr    = miss_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && hit_cnt_q != 32'hFFFF_FFFF)         hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_start && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = 32'h0;
  assign bus.miss_count = 32'h0;
`endif
endmodule

// File: tb/tb_icache_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_responder
//   Directed vector tables, an asynchronous-reset sequence and a randomized
//   run, all checked against a line-level reference model of the cache.
// ---------------------------------------------------------------------------
module tb_icache_responder;
  localparam int NSETS = 16;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  icache_responder_if bus ();

  icache_responder #(.NUM_SETS(NSETS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        flush;
    logic        wt;
    logic [31:0] load;
    logic        exp_hit;
    logic [31:0] exp_load;
    logic        exp_iren;
    logic [31:0] exp_iaddr;
  } vec_t;

  vec_t tbl[$];

  // Reference model: each line remembers the full word address it holds.
  bit          m_valid     [NSETS];
  logic [31:0] m_line_addr [NSETS];
  logic [31:0] m_data      [NSETS];
  bit          m_busy;
  logic [31:0] m_pending;
  longint      m_hits;
  longint      m_misses;

  function automatic vec_t mk(logic r, logic [31:0] a, logic f, logic w, logic [31:0] l,
                              logic eh, logic [31:0] el, logic er, logic [31:0] ea);
    vec_t v;
    v.ren = r; v.addr = a; v.flush = f; v.wt = w; v.load = l;
    v.exp_hit = eh; v.exp_load = el; v.exp_iren = er; v.exp_iaddr = ea;
    return v;
  endfunction

  function automatic logic [31:0] sat32(longint n);
    return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    m_busy    = 1'b0;
    m_pending = 32'h0;
    m_hits    = 0;
    m_misses  = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, check 1ns later, advance model.
  task automatic step(input logic ren, input logic [31:0] addr, input logic fl,
                      input logic wt, input logic [31:0] ld,
                      input bit use_tbl, input vec_t v, input string nm);
    int          idx;
    logic        e_hit;
    logic [31:0] e_load;
    logic [31:0] word;
    @(negedge CLK);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.iflush   = fl;
    bus.iwait    = wt;
    bus.iload    = ld;
    #1;
    word   = {addr[31:2], 2'b00};
    idx    = int'((addr >> 2) % NSETS);
    e_hit  = !m_busy && ren && !fl && m_valid[idx] && (m_line_addr[idx] == word);
    e_load = e_hit ? m_data[idx] : 32'h0;

    chk({nm, ".ihit"},     {31'h0, bus.ihit}, {31'h0, e_hit});
    chk({nm, ".imemload"}, bus.imemload,       e_load);
    chk({nm, ".iREN"},     {31'h0, bus.iREN}, {31'h0, m_busy});
    if (m_busy) chk({nm, ".iaddr"}, bus.iaddr, m_pending);
    chk({nm, ".hit_count"},  bus.hit_count,  STATS ? sat32(m_hits)   : 32'h0);
    chk({nm, ".miss_count"}, bus.miss_count, STATS ? sat32(m_misses) : 32'h0);

    if (use_tbl) begin
      chk({nm, ".tbl_ihit"},     {31'h0, bus.ihit}, {31'h0, v.exp_hit});
      chk({nm, ".tbl_imemload"}, bus.imemload,       v.exp_load);
      chk({nm, ".tbl_iREN"},     {31'h0, bus.iREN}, {31'h0, v.exp_iren});
      if (v.exp_iren) chk({nm, ".tbl_iaddr"}, bus.iaddr, v.exp_iaddr);
      $display("%s ren=%0b addr=%h flush=%0b iwait=%0b -> ihit=%0b imemload=%h iREN=%0b iaddr=%h",
               nm, ren, addr, fl, wt, bus.ihit, bus.imemload, bus.iREN, bus.iaddr);
    end

    if (fl) for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    if (m_busy && !wt) begin
      idx = int'((m_pending >> 2) % NSETS);
      m_valid[idx]     = 1'b1;
      m_line_addr[idx] = m_pending;
      m_data[idx]      = ld;
      m_busy           = 1'b0;
      if (!use_tbl) $display("%s fill addr=%h data=%h", nm, m_pending, ld);
    end else if (!m_busy && ren && !e_hit) begin
      m_busy    = 1'b1;
      m_pending = word;
      m_misses++;
    end
    if (e_hit) m_hits++;
  endtask

  task automatic cyc(input logic ren, input logic [31:0] addr, input logic wt,
                     input logic [31:0] ld, input string nm);
    vec_t dummy;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(ren, addr, 1'b0, wt, ld, 1'b0, dummy, nm);
  endtask

  initial begin
    logic [31:0] X, L0, W, A, B, C, D, E, F, G;
    vec_t        dummy;
    checks   = 0;
    failures = 0;
    X  = 32'hDEAD_BEEF; L0 = 32'h2001_0005; W = 32'h1111_2222;
    A  = 32'hAAAA_0000; B  = 32'hBBBB_0040;
    C  = 32'hC0C0_0100; D  = 32'hD0D0_0204;
    E  = 32'hE000_0010; F  = 32'hF000_0014; G = 32'h6000_0018;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Cold miss with zero-wait memory, then wait states.
    tbl.push_back(mk(1, 32'h40, 0, 0, L0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, L0, 0, 0,  1, 32'h40));
    tbl.push_back(mk(1, 32'h40, 0, 0, L0, 1, L0, 0, 0));
    tbl.push_back(mk(1, 32'h80, 0, 1, X,  0, 0,  0, 0));
    tbl.push_back(mk(1, 32'h80, 0, 1, X,  0, 0,  1, 32'h80));
    tbl.push_back(mk(1, 32'h80, 0, 1, X,  0, 0,  1, 32'h80));
    tbl.push_back(mk(1, 32'h80, 0, 1, X,  0, 0,  1, 32'h80));
    tbl.push_back(mk(1, 32'h80, 0, 0, W,  0, 0,  1, 32'h80));
    tbl.push_back(mk(1, 32'h80, 0, 0, W,  1, W,  0, 0));
    // Conflict eviction on index 0.
    tbl.push_back(mk(1, 32'h00, 0, 0, A, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h00, 0, 0, A, 0, 0, 1, 32'h00));
    tbl.push_back(mk(1, 32'h00, 0, 0, A, 1, A, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, B, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, B, 0, 0, 1, 32'h40));
    tbl.push_back(mk(1, 32'h40, 0, 0, B, 1, B, 0, 0));
    tbl.push_back(mk(1, 32'h00, 0, 0, A, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h00, 0, 0, A, 0, 0, 1, 32'h00));
    tbl.push_back(mk(1, 32'h00, 0, 0, A, 1, A, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, B, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, B, 0, 0, 1, 32'h40));
    tbl.push_back(mk(1, 32'h40, 0, 0, B, 1, B, 0, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, X, 0, 0, 0, 0));
    // Address change while the miss is outstanding.
    tbl.push_back(mk(1, 32'h100, 0, 1, X, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h204, 0, 1, X, 0, 0, 1, 32'h100));
    tbl.push_back(mk(1, 32'h204, 0, 0, C, 0, 0, 1, 32'h100));
    tbl.push_back(mk(1, 32'h204, 0, 1, X, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h204, 0, 0, D, 0, 0, 1, 32'h204));
    tbl.push_back(mk(1, 32'h100, 0, 0, X, 1, C, 0, 0));
    tbl.push_back(mk(1, 32'h206, 0, 0, X, 1, D, 0, 0));
    // Flush behaviour, including a flush coincident with a fill.
    tbl.push_back(mk(1, 32'h10, 0, 0, E, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0, E, 0, 0, 1, 32'h10));
    tbl.push_back(mk(1, 32'h14, 0, 0, F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h14, 0, 0, F, 0, 0, 1, 32'h14));
    tbl.push_back(mk(1, 32'h10, 0, 0, X, 1, E, 0, 0));
    tbl.push_back(mk(1, 32'h10, 1, 0, E, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0, E, 0, 0, 1, 32'h10));
    tbl.push_back(mk(0, 32'h10, 1, 0, X, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0, E, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0, E, 0, 0, 1, 32'h10));
    tbl.push_back(mk(1, 32'h14, 0, 0, F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h14, 0, 0, F, 0, 0, 1, 32'h14));
    tbl.push_back(mk(1, 32'h18, 0, 0, G, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h18, 1, 0, G, 0, 0, 1, 32'h18));
    tbl.push_back(mk(1, 32'h18, 0, 0, X, 1, G, 0, 0));
    tbl.push_back(mk(1, 32'h14, 0, 0, F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h14, 0, 0, F, 0, 0, 1, 32'h14));
    tbl.push_back(mk(1, 32'h10, 0, 0, X, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h10, 0, 0, E, 0, 0, 1, 32'h10));

    // Reset state.
    RST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = 32'h0; bus.iflush = 1'b0;
    bus.iwait = 1'b0;   bus.iload = 32'h0;
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    chk("reset.ihit",       {31'h0, bus.ihit}, 32'h0);
    chk("reset.imemload",   bus.imemload,       32'h0);
    chk("reset.iREN",       {31'h0, bus.iREN}, 32'h0);
    chk("reset.iaddr",      bus.iaddr,          32'h0);
    chk("reset.hit_count",  bus.hit_count,      32'h0);
    chk("reset.miss_count", bus.miss_count,     32'h0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].ren, tbl[i].addr, tbl[i].flush, tbl[i].wt, tbl[i].load,
           1'b1, tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Asynchronous reset in the middle of a miss.
    cyc(1, 32'h300, 1, X, "arst.miss");
    cyc(1, 32'h300, 1, X, "arst.wait");
    #2;
    RST = 1'b1;
    #1;
    chk("arst.iREN",       {31'h0, bus.iREN}, 32'h0);
    chk("arst.iaddr",      bus.iaddr,          32'h0);
    chk("arst.hit_count",  bus.hit_count,      32'h0);
    chk("arst.miss_count", bus.miss_count,     32'h0);
    model_reset();
    bus.imemREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    $display("arst released");
    // Line refetches, then three hits.
    cyc(1, 32'h300, 0, 32'h3300_0300, "post.miss");
    cyc(1, 32'h300, 0, 32'h3300_0300, "post.fill");
    cyc(1, 32'h300, 0, X, "post.hit1");
    cyc(1, 32'h304, 0, X, "post.miss2");
    cyc(1, 32'h304, 0, 32'h3300_0304, "post.fill2");
    cyc(1, 32'h300, 0, X, "post.hit2");
    cyc(1, 32'h304, 0, X, "post.hit3");
    cyc(0, 32'h0,   0, X, "post.idle");
    chk("stats.hit_count",  bus.hit_count,  STATS ? 32'd3 : 32'd0);
    chk("stats.miss_count", bus.miss_count, STATS ? 32'd2 : 32'd0);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) << 6) | ($urandom_range(0, NSETS - 1) << 2) |
           $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) ra = ra | 32'h8000_0000;
      step(($urandom_range(0, 9) < 8), ra, ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 4), $urandom, 1'b0, dummy,
           $sformatf("rnd[%0d]", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
